mini_i_fetch: RTL and testbench

Instruction fetch stage directly upstream of `mini_i_cache`. It holds the program counter and issues sequential word fetches on the cache's `ir_*` request/response channel, with up to `max_outstanding` requests in flight. Returned instructions are buffered with their PCs in a small FIFO toward the decoder. A redirect input flushes the FIFO, discards in-flight responses and restarts fetch at a new PC.

---
 rtl/mini_i_fetch.sv | 159 +++++++++++++++
 tb/tb_mini_i_fetch.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mini_i_fetch.sv
// Instruction fetch stage: sequential PC fetch over a credit-limited request/response
// channel to the instruction cache, with a small {pc, instr} FIFO toward the decoder.
module mini_i_fetch #(
    parameter int data_width      = 32,
    parameter int addr_width      = 32,
    parameter int fifo_depth      = 4,
    parameter int max_outstanding = 2,
    parameter logic [addr_width-1:0] reset_pc = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  ir_addr_valid,
    input  logic                  ir_addr_ready,
    output logic [addr_width-1:0] ir_addr,
    input  logic                  ir_data_valid,
    output logic                  ir_data_ready,
    input  logic [data_width-1:0] ir_data,
    input  logic                  redirect_valid,
    input  logic [addr_width-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] out_instr,
    output logic [addr_width-1:0] out_pc
);

    localparam int ow = $clog2(max_outstanding + 1);
    localparam int cw = $clog2(fifo_depth + 1);
    localparam int fw = $clog2(fifo_depth);
    localparam int qw = (max_outstanding > 1) ? $clog2(max_outstanding) : 1;

    localparam logic [ow-1:0] max_out_c = ow'(max_outstanding);
    localparam logic [cw:0]   depth_c   = (cw + 1)'(fifo_depth);
    localparam logic [cw-1:0] full_c    = cw'(fifo_depth);
    localparam logic [qw-1:0] q_last_c  = qw'(max_outstanding - 1);

    logic [addr_width-1:0] pc_q, pc_d;
    logic [ow-1:0]         outstanding_q, outstanding_d;
    logic [ow-1:0]         drop_count_q, drop_count_d;
    logic [cw-1:0]         count_q, count_d;
    logic [fw-1:0]         rd_ptr_q, rd_ptr_d;
    logic [fw-1:0]         wr_ptr_q, wr_ptr_d;
    logic [qw-1:0]         rq_rd_q, rq_rd_d;
    logic [qw-1:0]         rq_wr_q, rq_wr_d;

    logic [addr_width-1:0] fifo_pc_q    [fifo_depth];
    logic [data_width-1:0] fifo_instr_q [fifo_depth];
    logic [addr_width-1:0] resp_pc_q    [max_outstanding];

    logic          req_fire;
    logic          resp_fire;
    logic          pop;
    logic          push;
    logic [cw:0]   credit_sum;

    function automatic logic [qw-1:0] q_next(input logic [qw-1:0] p);
        if (p == q_last_c) begin
            return '0;
        end
        return p + qw'(1);
    endfunction

    // Reserving a FIFO slot per in-flight request means responses never need to stall.
    assign credit_sum    = {1'b0, count_q} + (cw + 1)'(outstanding_q);
    assign ir_addr_valid = reset && !redirect_valid
                           && (outstanding_q < max_out_c) && (credit_sum < depth_c);
    assign ir_addr       = pc_q;
    assign ir_data_ready = reset;

    assign out_valid = (count_q != '0);
    assign out_instr = out_valid ? fifo_instr_q[rd_ptr_q] : '0;
    assign out_pc    = out_valid ? fifo_pc_q[rd_ptr_q] : '0;

    assign req_fire  = ir_addr_valid && ir_addr_ready;
    assign resp_fire = ir_data_valid && ir_data_ready;
    assign pop       = out_valid && out_ready && !redirect_valid;
    assign push      = resp_fire && (drop_count_q == '0) && !redirect_valid;

    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q + ow'(req_fire) - ow'(resp_fire);
        drop_count_d  = drop_count_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        rq_rd_d       = rq_rd_q;
        rq_wr_d       = rq_wr_q;

        if (req_fire) begin
            rq_wr_d = q_next(rq_wr_q);
        end
        if (resp_fire) begin
            rq_rd_d = q_next(rq_rd_q);
        end

        if (redirect_valid) begin
            // Everything still in flight after this edge belongs to the old path.
            pc_d         = redirect_pc;
            drop_count_d = outstanding_q - ow'(resp_fire);
            count_d      = '0;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
        end else begin
            if (req_fire) begin
                pc_d = pc_q + addr_width'(4);
            end
            if (resp_fire && (drop_count_q != '0)) begin
                drop_count_d = drop_count_q - ow'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + fw'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + fw'(1);
            end
            count_d = count_q + cw'(push) - cw'(pop);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q          <= reset_pc;
            outstanding_q <= '0;
            drop_count_q  <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            rq_rd_q       <= '0;
            rq_wr_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_count_q  <= drop_count_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            rq_rd_q       <= rq_rd_d;
            rq_wr_q       <= rq_wr_d;
        end
    end

    // Storage only; validity is tracked by the pointers and counters above.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]    <= resp_pc_q[rq_rd_q];
            fifo_instr_q[wr_ptr_q] <= ir_data;
        end
        if (req_fire) begin
            resp_pc_q[rq_wr_q] <= pc_q;
        end
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
        !(push && !pop && (count_q == full_c)));
    a_no_over_issue: assert property (@(posedge clock) disable iff (!reset)
        !(req_fire && (outstanding_q == max_out_c)));
    a_no_spurious_resp: assert property (@(posedge clock) disable iff (!reset)
        !(resp_fire && (outstanding_q == '0)));

endmodule

// File: tb/tb_mini_i_fetch.sv
// Bench for mini_i_fetch: per-cycle directed table, then cache-model sequences for
// redirects, wrap-around and mid-flight reset.
module tb_mini_i_fetch;

    localparam logic [31:0] KEY = 32'hA5A5A5A5;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ir_addr_valid;
    logic        ir_addr_ready;
    logic [31:0] ir_addr;
    logic        ir_data_valid;
    logic        ir_data_ready;
    logic [31:0] ir_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    always #5 clock = ~clock;

    mini_i_fetch #(
        .data_width(32),
        .addr_width(32),
        .fifo_depth(4),
        .max_outstanding(2),
        .reset_pc(32'h100)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ir_addr_valid(ir_addr_valid),
        .ir_addr_ready(ir_addr_ready),
        .ir_addr(ir_addr),
        .ir_data_valid(ir_data_valid),
        .ir_data_ready(ir_data_ready),
        .ir_data(ir_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc)
    );

    typedef struct {
        logic        ordy;
        logic        ardy;
        logic        dv;
        logic [31:0] data;
        logic        redir;
        logic [31:0] rpc;
        logic        e_av;
        logic [31:0] e_addr;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t        tbl [14];
    int          total  = 0;
    int          passed = 0;
    logic [31:0] cq [$];
    logic [31:0] log_pc [$];
    logic [31:0] log_instr [$];
    logic        addr_en;
    logic        resp_en;
    logic        xseen;

    function automatic vec_t mk(input logic ordy, input logic ardy, input logic dv,
                                input logic [31:0] data, input logic redir,
                                input logic [31:0] rpc, input logic e_av,
                                input logic [31:0] e_addr, input logic e_ov,
                                input logic [31:0] e_pc, input logic [31:0] e_instr);
        vec_t v;
        v.ordy = ordy; v.ardy = ardy; v.dv = dv; v.data = data;
        v.redir = redir; v.rpc = rpc; v.e_av = e_av; v.e_addr = e_addr;
        v.e_ov = e_ov; v.e_pc = e_pc; v.e_instr = e_instr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One clock cycle with the cache model driving the response side.
    task automatic tick();
        logic        rf;
        logic        pf;
        logic        popf;
        logic [31:0] ra;
        ir_addr_ready = addr_en;
        if (cq.size() > 0) begin
            ir_data_valid = resp_en;
            ir_data       = cq[0] ^ KEY;
        end else begin
            ir_data_valid = 1'b0;
            ir_data       = '0;
        end
        #1;
        if ($isunknown({ir_addr_valid, ir_addr, ir_data_ready, out_valid, out_instr, out_pc}))
            xseen = 1'b1;
        rf   = ir_addr_valid && ir_addr_ready;
        ra   = ir_addr;
        pf   = ir_data_valid && ir_data_ready;
        popf = out_valid && out_ready && !redirect_valid;
        if (popf) begin
            log_pc.push_back(out_pc);
            log_instr.push_back(out_instr);
        end
        @(posedge clock);
        #1;
        if (pf) void'(cq.pop_front());
        if (rf) cq.push_back(ra);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic check_log(input string nm, input logic [31:0] p0,
                             input logic [31:0] p1, input logic [31:0] p2);
        logic [31:0] exp_pc [3];
        exp_pc[0] = p0;
        exp_pc[1] = p1;
        exp_pc[2] = p2;
        chk({nm, "_count_ok"}, 32'(log_pc.size() >= 3), 32'd1);
        for (int i = 0; i < 3; i++) begin
            if (i < log_pc.size()) begin
                chk($sformatf("%s_pc%0d", nm, i), log_pc[i], exp_pc[i]);
                chk($sformatf("%s_instr%0d", nm, i), log_instr[i], exp_pc[i] ^ KEY);
            end
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_av"}, 32'(ir_addr_valid), 32'd0);
        chk({nm, "_dready"}, 32'(ir_data_ready), 32'd0);
        chk({nm, "_addr"}, ir_addr, 32'h100);
        chk({nm, "_ov"}, 32'(out_valid), 32'd0);
        chk({nm, "_instr"}, out_instr, 32'd0);
        chk({nm, "_pc"}, out_pc, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        ir_addr_ready  = 1'b0;
        ir_data_valid  = 1'b0;
        ir_data        = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        addr_en        = 1'b0;
        resp_en        = 1'b0;
        xseen          = 1'b0;

        //            ordy ardy dv  data           rd  rpc     av  addr    ov  pc      instr
        tbl[0]  = mk(1, 1, 0, 32'h0,        0, 32'h0,   1, 32'h100, 0, 32'h0,   32'h0);
        tbl[1]  = mk(1, 1, 1, 32'hA5A5A4A5, 0, 32'h0,   1, 32'h104, 0, 32'h0,   32'h0);
        tbl[2]  = mk(1, 1, 1, 32'hA5A5A4A1, 0, 32'h0,   1, 32'h108, 1, 32'h100, 32'hA5A5A4A5);
        tbl[3]  = mk(0, 1, 1, 32'hA5A5A4AD, 0, 32'h0,   1, 32'h10C, 1, 32'h104, 32'hA5A5A4A1);
        tbl[4]  = mk(0, 1, 1, 32'hA5A5A4A9, 0, 32'h0,   1, 32'h110, 1, 32'h104, 32'hA5A5A4A1);
        tbl[5]  = mk(0, 1, 1, 32'hA5A5A4B5, 0, 32'h0,   0, 32'h114, 1, 32'h104, 32'hA5A5A4A1);
        tbl[6]  = mk(0, 1, 0, 32'h0,        0, 32'h0,   0, 32'h114, 1, 32'h104, 32'hA5A5A4A1);
        tbl[7]  = mk(1, 1, 0, 32'h0,        0, 32'h0,   0, 32'h114, 1, 32'h104, 32'hA5A5A4A1);
        tbl[8]  = mk(1, 1, 0, 32'h0,        0, 32'h0,   1, 32'h114, 1, 32'h108, 32'hA5A5A4AD);
        tbl[9]  = mk(1, 0, 1, 32'hA5A5A4B1, 0, 32'h0,   1, 32'h118, 1, 32'h10C, 32'hA5A5A4A9);
        tbl[10] = mk(1, 0, 0, 32'h0,        0, 32'h0,   1, 32'h118, 1, 32'h110, 32'hA5A5A4B5);
        tbl[11] = mk(1, 0, 0, 32'h0,        0, 32'h0,   1, 32'h118, 1, 32'h114, 32'hA5A5A4B1);
        tbl[12] = mk(1, 1, 0, 32'h0,        1, 32'h200, 0, 32'h118, 0, 32'h0,   32'h0);
        tbl[13] = mk(1, 0, 0, 32'h0,        0, 32'h0,   1, 32'h200, 0, 32'h0,   32'h0);

        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            out_ready      = tbl[i].ordy;
            ir_addr_ready  = tbl[i].ardy;
            ir_data_valid  = tbl[i].dv;
            ir_data        = tbl[i].data;
            redirect_valid = tbl[i].redir;
            redirect_pc    = tbl[i].rpc;
            #1;
            chk($sformatf("row%0d_av", i), 32'(ir_addr_valid), 32'(tbl[i].e_av));
            chk($sformatf("row%0d_addr", i), ir_addr, tbl[i].e_addr);
            chk($sformatf("row%0d_dready", i), 32'(ir_data_ready), 32'd1);
            chk($sformatf("row%0d_ov", i), 32'(out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("row%0d_pc", i), out_pc, tbl[i].e_pc);
            chk($sformatf("row%0d_instr", i), out_instr, tbl[i].e_instr);
            @(posedge clock);
            #1;
        end
        redirect_valid = 1'b0;

        // Redirect to 0, get 0x0/0x4 into the FIFO and 0x8/0xC in flight.
        out_ready = 1'b1; addr_en = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h0; resp_en = 1'b0; tick();
        redirect_valid = 1'b0; tick(); tick();
        out_ready = 1'b0; resp_en = 1'b1; tick(); tick();
        resp_en = 1'b0; tick();
        chk("bp_ov", 32'(out_valid), 32'd1);
        chk("bp_head_pc", out_pc, 32'h0);
        log_pc.delete(); log_instr.delete();
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200; tick();
        redirect_valid = 1'b0; resp_en = 1'b1; run(10);
        check_log("redir2", 32'h200, 32'h204, 32'h208);

        // Redirect in the same cycle as a response, with a second response still pending.
        resp_en = 1'b0; tick();
        log_pc.delete(); log_instr.delete();
        redirect_valid = 1'b1; redirect_pc = 32'h300; resp_en = 1'b1; tick();
        redirect_valid = 1'b0; run(10);
        check_log("redir_resp", 32'h300, 32'h304, 32'h308);

        redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFF8; tick();
        log_pc.delete(); log_instr.delete();
        redirect_valid = 1'b0; run(10);
        check_log("wrap", 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0);

        // Asynchronous reset in the middle of a cycle with two requests outstanding.
        resp_en = 1'b0; tick(); tick();
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("midreset");
        cq.delete();
        @(posedge clock);
        #1;
        reset = 1'b1;
        log_pc.delete(); log_instr.delete();
        #1;
        chk("post_reset_av", 32'(ir_addr_valid), 32'd1);
        chk("post_reset_addr", ir_addr, 32'h100);
        resp_en = 1'b1; run(10);
        check_log("post_reset", 32'h100, 32'h104, 32'h108);

        chk("no_x", 32'(xseen), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
